// File: rtl/vuvmu_dcache_arb_pkg.sv
// rtl/vuvmu_dcache_arb_pkg.sv - shared constants, FSM encoding and tag helper for the D$ arbiter
package vuvmu_dcache_arb_pkg;

    localparam int ADDR_W      = 30;
    localparam int TAG_W       = 12;
    localparam int DATA_W      = 64;
    localparam int WMASK_W     = 8;
    localparam int OP_W        = 4;

    // Tag bit that carries the source ID on the way to the D$ and back.
    localparam int TAG_SRC_BIT = 11;

    // Write-no-response op: never consumes a credit.
    localparam logic [OP_W-1:0] M_XWR = 4'b0001;

    localparam logic SRC_V = 1'b0;
    localparam logic SRC_U = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    // Replace the source-ID bit of a request tag with the granted source.
    function automatic logic [TAG_W-1:0] stamp_tag(input logic src, input logic [TAG_W-1:0] tag);
        return {src, tag[TAG_SRC_BIT-1:0]};
    endfunction

endpackage

// File: rtl/vuvmu_dcache_arb_credit.sv
// rtl/vuvmu_dcache_arb_credit.sv - per-source outstanding-response credit counter
module vuvmu_dcache_arb_credit
    import vuvmu_dcache_arb_pkg::*;
#(
    parameter int MAX_OUT = 8,
    parameter int CNT_SZ  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [CNT_SZ-1:0] cnt_o,
    output logic              full_o
);

    logic [CNT_SZ-1:0] cnt_q;
    logic [CNT_SZ-1:0] cnt_d;
    logic              underflow;

    // A response with nothing outstanding is absorbed; the count saturates at 0.
    assign underflow = dec_i && !inc_i && (cnt_q == '0);

    // Next count: simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_SZ'(1);
        end else if (dec_i && !inc_i && !underflow) begin
            cnt_d = cnt_q - CNT_SZ'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // Report responses that arrive with no request outstanding.
    always_ff @(posedge clk_i) begin
        if (reset_i && underflow) begin
            $display("%m: credit underflow, response with zero outstanding, count held at 0");
        end
    end
`endif

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q >= CNT_SZ'(MAX_OUT));

endmodule

// File: rtl/vuvmu_dcache_arb.sv
// rtl/vuvmu_dcache_arb.sv - round-robin arbiter sharing the D$ port between vector and UT VMU paths
module vuvmu_dcache_arb
    import vuvmu_dcache_arb_pkg::*;
#(
    parameter int MAX_OUT = 8,
    parameter int CNT_SZ  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [ADDR_W-1:0]  vreq_addr_i,
    input  logic [TAG_W-1:0]   vreq_tag_i,
    input  logic [DATA_W-1:0]  vreq_data_i,
    input  logic [WMASK_W-1:0] vreq_wmask_i,
    input  logic [OP_W-1:0]    vreq_op_i,
    input  logic               vreq_val_i,
    output logic               vreq_rdy_o,

    input  logic [ADDR_W-1:0]  ureq_addr_i,
    input  logic [TAG_W-1:0]   ureq_tag_i,
    input  logic [DATA_W-1:0]  ureq_data_i,
    input  logic [WMASK_W-1:0] ureq_wmask_i,
    input  logic [OP_W-1:0]    ureq_op_i,
    input  logic               ureq_val_i,
    output logic               ureq_rdy_o,

    output logic [ADDR_W-1:0]  dcachereq_addr_o,
    output logic [TAG_W-1:0]   dcachereq_tag_o,
    output logic [DATA_W-1:0]  dcachereq_data_o,
    output logic [WMASK_W-1:0] dcachereq_wmask_o,
    output logic [OP_W-1:0]    dcachereq_op_o,
    output logic               dcachereq_val_o,
    input  logic               dcachereq_rdy_i,

    input  logic [DATA_W-1:0]  dcacheresp_data_i,
    input  logic [TAG_W-1:0]   dcacheresp_tag_i,
    input  logic               dcacheresp_val_i,
    output logic               vresp_val_o,
    output logic               uresp_val_o,

    input  logic               fence_req_i,
    output logic               fence_done_o,
    output logic               busy_o
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;

    logic [CNT_SZ-1:0] vcnt, ucnt;
    logic              v_full, u_full;
    logic              accept;
    logic              v_elig, u_elig;
    logic              grant_u;
    logic              req_val;
    logic              fire;
    logic              v_inc, u_inc, v_dec, u_dec;
    logic              resp_src;

    // Response data and the low tag bits pass straight to both consumers; the
    // incoming request tag[11] is overwritten by the source stamp.
    logic              unused_ok;
    assign unused_ok = &{1'b0, vreq_tag_i[TAG_SRC_BIT], ureq_tag_i[TAG_SRC_BIT],
                         dcacheresp_data_i, dcacheresp_tag_i[TAG_SRC_BIT-1:0]};

    // Grants stop the very cycle a fence is raised, not one cycle later.
    assign accept = (state_q == ST_RUN) && !fence_req_i;
    assign v_elig = vreq_val_i && accept && ((vreq_op_i == M_XWR) || !v_full);
    assign u_elig = ureq_val_i && accept && ((ureq_op_i == M_XWR) || !u_full);

    // Round-robin pick: on contention favour the source that did not win last.
    always_comb begin
        grant_u = SRC_V;
        if (v_elig && u_elig) begin
            grant_u = ~last_grant_q;
        end else if (u_elig) begin
            grant_u = SRC_U;
        end
    end

    assign req_val = v_elig || u_elig;
    assign fire    = req_val && dcachereq_rdy_i;

    assign dcachereq_val_o   = req_val;
    assign dcachereq_addr_o  = grant_u ? ureq_addr_i  : vreq_addr_i;
    assign dcachereq_data_o  = grant_u ? ureq_data_i  : vreq_data_i;
    assign dcachereq_wmask_o = grant_u ? ureq_wmask_i : vreq_wmask_i;
    assign dcachereq_op_o    = grant_u ? ureq_op_i    : vreq_op_i;
    assign dcachereq_tag_o   = grant_u ? stamp_tag(SRC_U, ureq_tag_i)
                                       : stamp_tag(SRC_V, vreq_tag_i);

    assign vreq_rdy_o = req_val && (grant_u == SRC_V) && dcachereq_rdy_i;
    assign ureq_rdy_o = req_val && (grant_u == SRC_U) && dcachereq_rdy_i;

    assign last_grant_d = fire ? grant_u : last_grant_q;

    assign resp_src    = dcacheresp_tag_i[TAG_SRC_BIT];
    assign vresp_val_o = dcacheresp_val_i && (resp_src == SRC_V);
    assign uresp_val_o = dcacheresp_val_i && (resp_src == SRC_U);

    assign v_inc = fire && (grant_u == SRC_V) && (vreq_op_i != M_XWR);
    assign u_inc = fire && (grant_u == SRC_U) && (ureq_op_i != M_XWR);
    assign v_dec = vresp_val_o;
    assign u_dec = uresp_val_o;

    vuvmu_dcache_arb_credit #(
        .MAX_OUT (MAX_OUT),
        .CNT_SZ  (CNT_SZ)
    ) u_vcredit (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (v_inc),
        .dec_i   (v_dec),
        .cnt_o   (vcnt),
        .full_o  (v_full)
    );

    vuvmu_dcache_arb_credit #(
        .MAX_OUT (MAX_OUT),
        .CNT_SZ  (CNT_SZ)
    ) u_ucredit (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (u_inc),
        .dec_i   (u_dec),
        .cnt_o   (ucnt),
        .full_o  (u_full)
    );

    // Fence FSM next state: drain on request, report done, release on drop.
    always_comb begin
        state_d      = state_q;
        fence_done_o = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (fence_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((vcnt == '0) && (ucnt == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fence_done_o = 1'b1;
                if (!fence_req_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_RUN;
            last_grant_q <= SRC_V;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy_o = (vcnt != '0) || (ucnt != '0) || vreq_val_i || ureq_val_i;

endmodule

// File: tb/tb_vuvmu_dcache_arb.sv
// tb/tb_vuvmu_dcache_arb.sv - scoreboard bench for the vector/UT D$ arbiter
module tb_vuvmu_dcache_arb;
    import vuvmu_dcache_arb_pkg::*;

    localparam logic [3:0]  OP_LD = 4'b0000;
    localparam logic [63:0] VDATA = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] UDATA = 64'h5A5A_3333_4444_5555;
    localparam logic [7:0]  VMASK = 8'hFF;
    localparam logic [7:0]  UMASK = 8'h0F;

    typedef struct {
        logic [29:0] addr;
        logic [11:0] tag;
        logic [3:0]  op;
        logic [63:0] data;
        logic [7:0]  wmask;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] vreq_addr, ureq_addr, dreq_addr;
    logic [11:0] vreq_tag, ureq_tag, dreq_tag, dresp_tag;
    logic [63:0] vreq_data, ureq_data, dreq_data, dresp_data;
    logic [7:0]  vreq_wmask, ureq_wmask, dreq_wmask;
    logic [3:0]  vreq_op, ureq_op, dreq_op;
    logic        vreq_val, vreq_rdy, ureq_val, ureq_rdy;
    logic        dreq_val, dreq_rdy, dresp_val;
    logic        vresp_val, uresp_val;
    logic        fence_req, fence_done, busy;

    req_t req_q[$];
    logic resp_q[$];
    req_t mon_e;
    logic mon_s;
    int   tests_run = 0;
    int   fails = 0;

    vuvmu_dcache_arb #(.MAX_OUT(8), .CNT_SZ(4)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .vreq_addr_i       (vreq_addr),
        .vreq_tag_i        (vreq_tag),
        .vreq_data_i       (vreq_data),
        .vreq_wmask_i      (vreq_wmask),
        .vreq_op_i         (vreq_op),
        .vreq_val_i        (vreq_val),
        .vreq_rdy_o        (vreq_rdy),
        .ureq_addr_i       (ureq_addr),
        .ureq_tag_i        (ureq_tag),
        .ureq_data_i       (ureq_data),
        .ureq_wmask_i      (ureq_wmask),
        .ureq_op_i         (ureq_op),
        .ureq_val_i        (ureq_val),
        .ureq_rdy_o        (ureq_rdy),
        .dcachereq_addr_o  (dreq_addr),
        .dcachereq_tag_o   (dreq_tag),
        .dcachereq_data_o  (dreq_data),
        .dcachereq_wmask_o (dreq_wmask),
        .dcachereq_op_o    (dreq_op),
        .dcachereq_val_o   (dreq_val),
        .dcachereq_rdy_i   (dreq_rdy),
        .dcacheresp_data_i (dresp_data),
        .dcacheresp_tag_i  (dresp_tag),
        .dcacheresp_val_i  (dresp_val),
        .vresp_val_o       (vresp_val),
        .uresp_val_o       (uresp_val),
        .fence_req_i       (fence_req),
        .fence_done_o      (fence_done),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input logic [29:0] a, input logic [11:0] t, input logic [3:0] o,
                           input logic [63:0] d, input logic [7:0] m);
        req_t e;
        e.addr = a; e.tag = t; e.op = o; e.data = d; e.wmask = m;
        req_q.push_back(e);
    endtask

    task automatic resp(input logic [11:0] t);
        dresp_val = 1'b1;
        dresp_tag = t;
        resp_q.push_back(t[11]);
    endtask

    // Monitor: every fire and every response is compared against the queues.
    always @(negedge clk) begin
        if (dreq_val && dreq_rdy) begin
            if (req_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL unexpected_fire: got addr %0h tag %0h expected no request", dreq_addr, dreq_tag);
            end else begin
                mon_e = req_q.pop_front();
                check("req_addr",  64'(dreq_addr),  64'(mon_e.addr));
                check("req_tag",   64'(dreq_tag),   64'(mon_e.tag));
                check("req_op",    64'(dreq_op),    64'(mon_e.op));
                check("req_data",  dreq_data,       mon_e.data);
                check("req_wmask", 64'(dreq_wmask), 64'(mon_e.wmask));
            end
        end
        if (dresp_val) begin
            if (resp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL unexpected_resp: got tag %0h expected no response", dresp_tag);
            end else begin
                mon_s = resp_q.pop_front();
                check("vresp_val", 64'(vresp_val), 64'(!mon_s));
                check("uresp_val", 64'(uresp_val), 64'(mon_s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; dreq_rdy = 1'b1; fence_req = 1'b0;
        vreq_val = 1'b0; vreq_addr = '0; vreq_tag = '0; vreq_op = OP_LD; vreq_data = VDATA; vreq_wmask = VMASK;
        ureq_val = 1'b0; ureq_addr = '0; ureq_tag = '0; ureq_op = OP_LD; ureq_data = UDATA; ureq_wmask = UMASK;
        dresp_val = 1'b0; dresp_tag = '0; dresp_data = 64'hDEAD_BEEF_0000_0001;

        // Reset state
        @(negedge clk);
        check("rst_dreq_val", 64'(dreq_val), 64'(0));
        check("rst_vreq_rdy", 64'(vreq_rdy), 64'(0));
        check("rst_ureq_rdy", 64'(ureq_rdy), 64'(0));
        check("rst_fence_done", 64'(fence_done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_vcnt", 64'(dut.u_vcredit.cnt_q), 64'(0));
        tick();
        reset = 1'b1;
        tick();

        // UT primer so that the round-robin then starts with vector
        ureq_val = 1'b1; ureq_addr = 30'h100; ureq_tag = 12'h005;
        exp_req(30'h100, 12'h805, OP_LD, UDATA, UMASK);
        tick();

        // Both sources valid: V,U,V,U with stamped tag bit 11
        vreq_val = 1'b1; vreq_tag = 12'hFFF; ureq_tag = 12'h00A;
        for (int i = 0; i < 4; i++) begin
            vreq_addr = 30'h200 + 30'(i);
            ureq_addr = 30'h300 + 30'(i);
            if (i % 2 == 0) exp_req(vreq_addr, 12'h7FF, OP_LD, VDATA, VMASK);
            else            exp_req(ureq_addr, 12'h80A, OP_LD, UDATA, UMASK);
            @(negedge clk);
            check("rr_vrdy", 64'(vreq_rdy), 64'(i % 2 == 0));
            check("rr_urdy", 64'(ureq_rdy), 64'(i % 2 == 1));
            tick();
        end
        vreq_val = 1'b0; ureq_val = 1'b0;
        @(negedge clk);
        check("rr_vcnt", 64'(dut.u_vcredit.cnt_q), 64'(2));
        check("rr_ucnt", 64'(dut.u_ucredit.cnt_q), 64'(3));
        check("rr_busy", 64'(busy), 64'(1));
        tick();
        resp(12'h805); tick();
        resp(12'h7FF); tick();
        resp(12'h805); tick();
        resp(12'h07F); tick();
        resp(12'h80A); tick();
        dresp_val = 1'b0;
        @(negedge clk);
        check("rr_vcnt_drained", 64'(dut.u_vcredit.cnt_q), 64'(0));
        check("rr_ucnt_drained", 64'(dut.u_ucredit.cnt_q), 64'(0));
        tick();

        // Credit limit: 8 vector loads, 9th held
        vreq_val = 1'b1; vreq_op = OP_LD; vreq_tag = 12'h010;
        for (int i = 0; i < 8; i++) begin
            vreq_addr = 30'h400 + 30'(i);
            exp_req(vreq_addr, 12'h010, OP_LD, VDATA, VMASK);
            tick();
        end
        vreq_addr = 30'h408;
        @(negedge clk);
        check("cr_held_rdy", 64'(vreq_rdy), 64'(0));
        check("cr_held_val", 64'(dreq_val), 64'(0));
        check("cr_vcnt_full", 64'(dut.u_vcredit.cnt_q), 64'(8));
        tick();

        // Stores bypass the credit limit
        vreq_op = M_XWR;
        for (int i = 0; i < 2; i++) begin
            vreq_addr = 30'h500 + 30'(i);
            exp_req(vreq_addr, 12'h010, M_XWR, VDATA, VMASK);
            @(negedge clk);
            check("st_rdy", 64'(vreq_rdy), 64'(1));
            tick();
        end

        // Blocked load; one vector response releases it on the next cycle
        vreq_op = OP_LD; vreq_addr = 30'h408;
        resp(12'h010);
        @(negedge clk);
        check("st_vcnt_kept", 64'(dut.u_vcredit.cnt_q), 64'(8));
        check("cr_resp_cycle_rdy", 64'(vreq_rdy), 64'(0));
        tick();
        dresp_val = 1'b0;
        exp_req(30'h408, 12'h010, OP_LD, VDATA, VMASK);
        @(negedge clk);
        check("cr_resume_rdy", 64'(vreq_rdy), 64'(1));
        tick();
        vreq_val = 1'b0;

        // Drain to 4, then fire and respond together
        for (int i = 0; i < 4; i++) begin
            resp(12'h010);
            tick();
        end
        dresp_val = 1'b0;
        @(negedge clk);
        check("sim_vcnt_before", 64'(dut.u_vcredit.cnt_q), 64'(4));
        tick();
        vreq_val = 1'b1; vreq_addr = 30'h600;
        exp_req(30'h600, 12'h010, OP_LD, VDATA, VMASK);
        resp(12'h010);
        tick();
        vreq_val = 1'b0; dresp_val = 1'b0;
        @(negedge clk);
        check("sim_vcnt_after", 64'(dut.u_vcredit.cnt_q), 64'(4));
        tick();
        for (int i = 0; i < 4; i++) begin
            resp(12'h010);
            tick();
        end
        dresp_val = 1'b0;

        // Fence with nothing outstanding reaches DONE two cycles later
        fence_req = 1'b1;
        @(negedge clk);
        check("f0_done_c0", 64'(fence_done), 64'(0));
        check("f0_state_c0", 64'(dut.state_q), 64'(ST_RUN));
        tick();
        @(negedge clk);
        check("f0_done_c1", 64'(fence_done), 64'(0));
        check("f0_state_c1", 64'(dut.state_q), 64'(ST_DRAIN));
        tick();
        fence_req = 1'b0;
        @(negedge clk);
        check("f0_done_c2", 64'(fence_done), 64'(1));
        tick();
        @(negedge clk);
        check("f0_state_run", 64'(dut.state_q), 64'(ST_RUN));
        tick();

        // Three UT loads outstanding, then fence
        ureq_val = 1'b1; ureq_op = OP_LD; ureq_tag = 12'h020;
        for (int i = 0; i < 3; i++) begin
            ureq_addr = 30'h700 + 30'(i);
            exp_req(ureq_addr, 12'h820, OP_LD, UDATA, UMASK);
            tick();
        end
        fence_req = 1'b1; ureq_addr = 30'h703;
        vreq_val = 1'b1; vreq_addr = 30'h800; vreq_tag = 12'h030;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fn_no_grant", 64'(dreq_val), 64'(0));
            check("fn_done_early", 64'(fence_done), 64'(0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            resp(12'h820);
            @(negedge clk);
            check("fn_no_grant_resp", 64'(dreq_val), 64'(0));
            check("fn_done_resp", 64'(fence_done), 64'(0));
            tick();
        end
        dresp_val = 1'b0;
        @(negedge clk);
        check("fn_ucnt_zero", 64'(dut.u_ucredit.cnt_q), 64'(0));
        check("fn_done_wait", 64'(fence_done), 64'(0));
        tick();
        fence_req = 1'b0; ureq_val = 1'b0;
        @(negedge clk);
        check("fn_done", 64'(fence_done), 64'(1));
        check("fn_done_no_grant", 64'(dreq_val), 64'(0));
        tick();
        exp_req(30'h800, 12'h030, OP_LD, VDATA, VMASK);
        @(negedge clk);
        check("fn_resume_rdy", 64'(vreq_rdy), 64'(1));
        tick();

        // Build vcnt=5, enter DRAIN, then reset
        for (int i = 1; i < 5; i++) begin
            vreq_addr = 30'h800 + 30'(i);
            exp_req(vreq_addr, 12'h030, OP_LD, VDATA, VMASK);
            tick();
        end
        vreq_val = 1'b0; fence_req = 1'b1;
        tick();
        @(negedge clk);
        check("rs_state_drain", 64'(dut.state_q), 64'(ST_DRAIN));
        check("rs_vcnt5", 64'(dut.u_vcredit.cnt_q), 64'(5));
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; fence_req = 1'b0;
        @(negedge clk);
        check("rs_vcnt0", 64'(dut.u_vcredit.cnt_q), 64'(0));
        check("rs_state_run", 64'(dut.state_q), 64'(ST_RUN));
        check("rs_fence_done", 64'(fence_done), 64'(0));
        tick();
        resp(12'h030);
        tick();
        dresp_val = 1'b0;
        @(negedge clk);
        check("rs_no_underflow", 64'(dut.u_vcredit.cnt_q), 64'(0));
        tick();
        tick();

        check("req_queue_empty", 64'(req_q.size()), 64'(0));
        check("resp_queue_empty", 64'(resp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/vuvmu_dcache_arb.md
# vuVMU_dcache_arb

Shares the single D$ request port between the vector (unit-stride/strided) VMU path and the utility (UT) VMU path. It arbitrates round-robin, stamps each request with a source ID in tag bit 11, and steers responses back by that bit. It limits each source's in-flight response-bearing requests with a credit counter and provides a fence that drains all outstanding traffic. It sits between the two VMU request queues and the D$.

## Interface
Parameters:
- MAX_OUT, 8: max in-flight response-bearing requests per source (1..15).
- CNT_SZ, 4: width of each outstanding counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; 0 = reset.
- vreq_addr/tag/data/wmask/op  in  30/12/64/8/4  vector-path request.
- vreq_val  in  1 / vreq_rdy  out  1  vector-path handshake.
- ureq_addr/tag/data/wmask/op  in  30/12/64/8/4  UT-path request.
- ureq_val  in  1 / ureq_rdy  out  1  UT-path handshake.
- dcachereq_addr/tag/data/wmask/op  out  30/12/64/8/4  to D$.
- dcachereq_val  out  1 / dcachereq_rdy  in  1  D$ handshake.
- dcacheresp_data  in  64, dcacheresp_tag  in  12, dcacheresp_val  in  1  D$ response.
- vresp_val, uresp_val  out  1  demuxed response valid (data/tag fanned out unchanged).
- fence_req  in  1  level: request drain.
- fence_done  out  1  drained.
- busy  out  1  any count nonzero or any request valid.

## Operation
- Eligible source: its val=1, FSM in RUN, and (op==M_XWR or count<MAX_OUT).
- Grant: one eligible source, round-robin. Register last_grant (reset 0 = vector) holds the last winner. If both are eligible, grant the source that is not last_grant. last_grant updates only on a fire (dcachereq_val & dcachereq_rdy).
- Output muxes follow the grant. dcachereq_tag = {src, req_tag[10:0]}, where src = 0 for vector and 1 for UT. The incoming tag[11] is ignored.
- rdy to the granted source = dcachereq_rdy. The other source's rdy = 0.
- Counters vcnt and ucnt:
  - +1 when that source fires with op≠M_XWR.
  - −1 when dcacheresp_val and resp_tag[11] selects that source.
  - Simultaneous +1 and −1 leave the counter unchanged.
  - A response when the counter is 0 leaves the counter at 0 and prints an error under `ifndef SYNTHESIS`.
- Response demux: vresp_val = dcacheresp_val & ~tag[11]; uresp_val = dcacheresp_val & tag[11].
- FSM:
  - RUN: fence_req=1 → DRAIN. No new grants from that cycle on.
  - DRAIN: vcnt==0 & ucnt==0 → DONE.
  - DONE: fence_done=1; fence_req=0 → RUN.
- reset=0 mid-operation: counters → 0, FSM → RUN, last_grant → 0. In-flight responses are then dropped for counting purposes (counters stay at 0).

## Timing
- Request path is fully combinational: val to dcachereq_val, and dcachereq_rdy to source rdy, in the same cycle with zero latency.
- Response demux is combinational. Counter updates become visible the next cycle.
- Credit check uses registered counts. A fire at count MAX_OUT−1 is allowed. The next cycle shows MAX_OUT and blocks that source.
- DRAIN→DONE takes 1 cycle after both counters read 0. A fence asserted with zero outstanding reaches DONE 2 cycles later.
- Reset values:
  - All val/rdy outputs are 0 while the sources are idle.
  - fence_done=0.
  - busy reflects its inputs only.

## Structure
- Shared package vuVMU_Ctrl_pkg (`vh` include) holds:
  - op constant M_XWR=4'b0001;
  - SRC_V=1'b0, SRC_U=1'b1;
  - FSM encodings ST_RUN/ST_DRAIN/ST_DONE;
  - the tag-bit-11 field position.
- Sub-module vuVMU_dcache_credit holds one counter with inc/dec/underflow check, instantiated twice.

## Test plan
- Both sources valid every cycle, all loads, dcachereq_rdy=1, responses returned 2 cycles later → grants alternate V,U,V,U; tags carry bit11 = 0,1,0,1.
- Vector path issues 8 loads with no responses, MAX_OUT=8 → the 9th request is held with vreq_rdy=0. One response with tag[11]=0 → issue resumes on the next cycle.
- Vector stores (op=M_XWR) while vcnt=8 → stores still fire and vcnt stays 8.
- 3 UT loads outstanding, then fence_req=1 → no grants occur. fence_done=1 exactly 1 cycle after the 3rd UT response. fence_req drops → RUN, and grants resume.
- A fire and a response on the same source in the same cycle with vcnt=4 → vcnt remains 4.
- reset=0 with vcnt=5 in DRAIN → next cycle vcnt=0, FSM RUN, fence_done=0. A late response causes no underflow below 0, and the error is printed.
